asm_fib_param: RTL and testbench

Parametrised iterative Fibonacci engine built as an ASM (idle/op/done) with a start/ready/done_tick handshake.
- Computes fib(din) for an IN_W-bit index into an OUT_W-bit registered result, flagging overflow with either wrap or saturate arithmetic.
- Supports abort mid-computation.
- Sits between the switch inputs and the seven-segment display driver, in the same slot as the previous fixed-width ASM example, and replaces it.

---
 rtl/asm_fib_param_if.sv | 57 +++++
 rtl/asm_fib_param.sv | 122 ++++++++++++
 tb/tb_asm_fib_param.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/asm_fib_param_if.sv
// ---------------------------------------------------------------------------
// asm_fib_param_if
//
// Purpose:
//   Bundles the start/ready/done_tick handshake and the data signals of the
//   iterative Fibonacci engine. Clock and reset stay outside the bundle as
//   plain ports of the engine itself.
//
// Signals:
//   i_start      request, sampled by the engine only while it is idle
//   i_abort      cancel, acted on by the engine only while it computes
//   i_din        Fibonacci index (IN_W bits), captured on the start edge
//   o_ready      high only while the engine is idle
//   o_busy       high only while the engine computes
//   o_done_tick  one-cycle pulse when a result has just been captured
//   o_dout       registered result (OUT_W bits)
//   o_ovf        registered overflow flag belonging to o_dout
//
// Modports:
//   master  the side that requests work (switch logic or a testbench)
//   slave   the Fibonacci engine
// ---------------------------------------------------------------------------
interface asm_fib_param_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 7
);
    logic             i_start;
    logic             i_abort;
    logic [IN_W-1:0]  i_din;
    logic             o_ready;
    logic             o_busy;
    logic             o_done_tick;
    logic [OUT_W-1:0] o_dout;
    logic             o_ovf;

    modport master (
        output i_start,
        output i_abort,
        output i_din,
        input  o_ready,
        input  o_busy,
        input  o_done_tick,
        input  o_dout,
        input  o_ovf
    );

    modport slave (
        input  i_start,
        input  i_abort,
        input  i_din,
        output o_ready,
        output o_busy,
        output o_done_tick,
        output o_dout,
        output o_ovf
    );
endinterface

// File: rtl/asm_fib_param.sv
// ---------------------------------------------------------------------------
// asm_fib_param
//
// Purpose:
//   Parametrised iterative Fibonacci engine written as a three-state ASM
//   (idle / op / done). On a start request it captures an IN_W-bit index and
//   then produces fib(index) into an OUT_W-bit registered result, one
//   addition per clock. Overflow is tracked with a sticky flag; the result
//   either wraps modulo 2^OUT_W (SAT = 0) or saturates to all-ones (SAT = 1).
//   A computation can be cancelled with abort, which leaves the previous
//   result untouched. Sits between the switch inputs and the seven-segment
//   display driver.
//
// Parameters:
//   IN_W   width of the index (default 4)
//   OUT_W  width of the result, at least 2 (default 7)
//   SAT    0 = wrap on overflow, 1 = saturate to all-ones
//
// Ports:
//   clk    system clock, every state change happens on its rising edge
//   reset  asynchronous reset, ACTIVE LOW
//   bus    handshake/data bundle (slave side), see asm_fib_param_if
// ---------------------------------------------------------------------------
module asm_fib_param #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 7,
    parameter bit SAT   = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    asm_fib_param_if.slave bus
);

    // State encoding of the ASM.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OP   = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [OUT_W-1:0] r_t0;
    logic [OUT_W-1:0] r_t1;
    logic [IN_W-1:0]  r_n;
    logic             r_of;
    logic [OUT_W-1:0] r_dout;
    logic             r_ovf;

    logic [OUT_W:0]   w_sum;
    logic             w_nZero;
    logic             w_nOne;

    // The adder is one bit wider than the operands so that its top bit is the
    // carry-out; the lower OUT_W bits are already the wrapped sum.
    assign w_sum   = {1'b0, r_t1} + {1'b0, r_t0};
    assign w_nZero = (r_n == '0);
    assign w_nOne  = (r_n == IN_W'(1));

    // Whole ASM in one sequential block. In idle a start loads the seed pair
    // (0, 1) and the index. In op, abort has top priority and simply returns
    // to idle without touching the result registers. Otherwise the pair is
    // advanced until the remaining count reaches one, at which point t1 holds
    // fib(index). An index of zero is handled by forcing t1 to zero on the
    // way out. The result registers are written only on the op->done edge,
    // so dout and ovf always describe the last completed computation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_t0    <= '0;
            r_t1    <= '0;
            r_n     <= '0;
            r_of    <= 1'b0;
            r_dout  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_t0    <= '0;
                        r_t1    <= OUT_W'(1);
                        r_n     <= bus.i_din;
                        r_of    <= 1'b0;
                        r_state <= S_OP;
                    end
                end
                S_OP: begin
                    if (bus.i_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_nZero) begin
                        // fib(0) = 0; no addition has happened, so no overflow.
                        r_t1    <= '0;
                        r_dout  <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (w_nOne) begin
                        r_dout  <= (SAT && r_of) ? '1 : r_t1;
                        r_ovf   <= r_of;
                        r_state <= S_DONE;
                    end else begin
                        r_t1 <= w_sum[OUT_W-1:0];
                        r_t0 <= r_t1;
                        r_n  <= r_n - IN_W'(1);
                        r_of <= r_of | w_sum[OUT_W];
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Status outputs are pure decodes of the state register, so they carry
    // no combinational path from any input.
    assign bus.o_ready     = (r_state == S_IDLE);
    assign bus.o_busy      = (r_state == S_OP);
    assign bus.o_done_tick = (r_state == S_DONE);
    assign bus.o_dout      = r_dout;
    assign bus.o_ovf       = r_ovf;

endmodule

// File: tb/tb_asm_fib_param.sv
// ---------------------------------------------------------------------------
// tb_asm_fib_param
//
// Purpose:
//   Self-checking bench for asm_fib_param. Two engines share clock, reset and
//   stimulus: one in wrap mode, one in saturate mode. Expected results come
//   from a hand-written vector table and from a plain-arithmetic Fibonacci
//   model for random indices.
// ---------------------------------------------------------------------------
module tb_asm_fib_param;

    localparam int IN_W  = 4;
    localparam int OUT_W = 7;

    logic clk = 1'b0;
    logic reset;

    int total = 0;
    int bad   = 0;

    // Expected dout of each engine from the previous completed operation.
    longint prevWrap = 0;
    longint prevSat  = 0;

    typedef struct {
        int din;
        int dinLater;
        int expWrap;
        int expOvfWrap;
        int expSat;
        int expOvfSat;
    } vecT;

    vecT vecs[7];

    asm_fib_param_if #(.IN_W(IN_W), .OUT_W(OUT_W)) busWrap ();
    asm_fib_param_if #(.IN_W(IN_W), .OUT_W(OUT_W)) busSat ();

    asm_fib_param #(.IN_W(IN_W), .OUT_W(OUT_W), .SAT(1'b0)) dutWrap (
        .clk   (clk),
        .reset (reset),
        .bus   (busWrap)
    );

    asm_fib_param #(.IN_W(IN_W), .OUT_W(OUT_W), .SAT(1'b1)) dutSat (
        .clk   (clk),
        .reset (reset),
        .bus   (busSat)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the same request to both engines.
    task automatic setInputs(input bit start, input bit abort, input int din);
        busWrap.i_start = start;
        busWrap.i_abort = abort;
        busWrap.i_din   = IN_W'(din);
        busSat.i_start  = start;
        busSat.i_abort  = abort;
        busSat.i_din    = IN_W'(din);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: exact Fibonacci number with plain integer arithmetic.
    function automatic longint fibOf(input int k);
        longint a = 0;
        longint b = 1;
        longint t;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic bit modelOvf(input int k);
        return fibOf(k) >= (longint'(1) << OUT_W);
    endfunction

    function automatic longint modelDout(input int k, input bit sat);
        longint f = fibOf(k);
        longint lim = longint'(1) << OUT_W;
        if (f >= lim)
            return sat ? (lim - 1) : (f % lim);
        return f;
    endfunction

    // One complete operation: start with dinVal, optionally change din to
    // dinLater right after the start edge, wait (bounded) for done_tick and
    // return what both engines present in the done cycle. Latency, busy
    // length, result stability during op and the return to ready are checked
    // on the way.
    task automatic applyStimulus(input string tag, input int dinVal, input int dinLater,
                                 output longint dWrap, output bit oWrap,
                                 output longint dSat, output bit oSat);
        int  expLat;
        int  lat;
        int  busyCnt;
        expLat  = (dinVal == 0) ? 1 : dinVal;
        setInputs(1'b1, 1'b0, dinVal);
        tick();
        setInputs(1'b0, 1'b0, (dinLater >= 0) ? dinLater : dinVal);
        checkOutput({tag, " dout held wrap"}, 32'(busWrap.o_dout), 32'(prevWrap));
        checkOutput({tag, " dout held sat"}, 32'(busSat.o_dout), 32'(prevSat));
        lat     = 0;
        busyCnt = 0;
        while (lat < 40 && !busWrap.o_done_tick) begin
            if (busWrap.o_busy && busSat.o_busy && !busWrap.o_ready)
                busyCnt++;
            tick();
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " busy cycles"}, 32'(busyCnt), 32'(expLat));
        checkOutput({tag, " done_tick sat"}, 32'(busSat.o_done_tick), 32'd1);
        checkOutput({tag, " ready in done"}, 32'(busWrap.o_ready), 32'd0);
        dWrap = longint'(busWrap.o_dout);
        oWrap = busWrap.o_ovf;
        dSat  = longint'(busSat.o_dout);
        oSat  = busSat.o_ovf;
        tick();
        checkOutput({tag, " ready after done"}, 32'(busWrap.o_ready), 32'd1);
        checkOutput({tag, " done_tick cleared"}, 32'(busWrap.o_done_tick), 32'd0);
    endtask

    initial begin
        longint dW, dS;
        bit     oW, oS;
        int     gap;
        int     pulses;
        int     d;
        int     dl;

        // Hand-derived results for OUT_W = 7 (limit 128).
        vecs[0] = '{din: 0,  dinLater: -1, expWrap: 0,  expOvfWrap: 0, expSat: 0,   expOvfSat: 0};
        vecs[1] = '{din: 1,  dinLater: -1, expWrap: 1,  expOvfWrap: 0, expSat: 1,   expOvfSat: 0};
        vecs[2] = '{din: 10, dinLater: 3,  expWrap: 55, expOvfWrap: 0, expSat: 55,  expOvfSat: 0};
        vecs[3] = '{din: 12, dinLater: -1, expWrap: 16, expOvfWrap: 1, expSat: 127, expOvfSat: 1};
        vecs[4] = '{din: 15, dinLater: -1, expWrap: 98, expOvfWrap: 1, expSat: 127, expOvfSat: 1};
        vecs[5] = '{din: 11, dinLater: -1, expWrap: 89, expOvfWrap: 0, expSat: 89,  expOvfSat: 0};
        vecs[6] = '{din: 10, dinLater: -1, expWrap: 55, expOvfWrap: 0, expSat: 55,  expOvfSat: 0};

        // Reset held with start high: engines must stay idle with cleared result.
        reset = 1'b0;
        setInputs(1'b1, 1'b0, 5);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset ready", 32'(busWrap.o_ready), 32'd1);
            checkOutput("reset busy", 32'(busWrap.o_busy), 32'd0);
            checkOutput("reset done_tick", 32'(busSat.o_done_tick), 32'd0);
            checkOutput("reset dout", 32'(busWrap.o_dout), 32'd0);
            checkOutput("reset ovf", 32'(busSat.o_ovf), 32'd0);
            tick();
        end
        setInputs(1'b0, 1'b0, 0);
        #2;
        reset = 1'b1;
        tick();

        // Table-driven operations.
        foreach (vecs[i]) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].din, vecs[i].dinLater, dW, oW, dS, oS);
            checkOutput($sformatf("vec%0d dout wrap", i), 32'(dW), 32'(vecs[i].expWrap));
            checkOutput($sformatf("vec%0d ovf wrap", i), 32'(oW), 32'(vecs[i].expOvfWrap));
            checkOutput($sformatf("vec%0d dout sat", i), 32'(dS), 32'(vecs[i].expSat));
            checkOutput($sformatf("vec%0d ovf sat", i), 32'(oS), 32'(vecs[i].expOvfSat));
            prevWrap = vecs[i].expWrap;
            prevSat  = vecs[i].expSat;
        end

        // Abort: start din=9, abort sampled at end of c+3, ready in c+4.
        setInputs(1'b1, 1'b0, 9);
        tick();
        setInputs(1'b0, 1'b0, 9);
        tick();
        setInputs(1'b0, 1'b1, 9);
        tick();
        setInputs(1'b0, 1'b0, 9);
        checkOutput("abort ready", 32'(busWrap.o_ready), 32'd1);
        checkOutput("abort busy", 32'(busSat.o_busy), 32'd0);
        checkOutput("abort dout wrap", 32'(busWrap.o_dout), 32'd55);
        checkOutput("abort dout sat", 32'(busSat.o_dout), 32'd55);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (busWrap.o_done_tick || busSat.o_done_tick)
                pulses++;
            tick();
        end
        checkOutput("abort no done_tick", 32'(pulses), 32'd0);
        applyStimulus("after abort", 5, -1, dW, oW, dS, oS);
        checkOutput("after abort dout", 32'(dW), 32'd5);
        checkOutput("after abort ovf", 32'(oW), 32'd0);
        prevWrap = 5;
        prevSat  = 5;

        // Random indices against the arithmetic model, with din scrambled mid-op.
        for (int i = 0; i < 16; i++) begin
            d  = int'($urandom_range(0, (1 << IN_W) - 1));
            dl = int'($urandom_range(0, (1 << IN_W) - 1));
            applyStimulus($sformatf("rnd%0d", i), d, dl, dW, oW, dS, oS);
            checkOutput($sformatf("rnd%0d dout wrap", i), 32'(dW), 32'(modelDout(d, 1'b0)));
            checkOutput($sformatf("rnd%0d ovf wrap", i), 32'(oW), 32'(modelOvf(d)));
            checkOutput($sformatf("rnd%0d dout sat", i), 32'(dS), 32'(modelDout(d, 1'b1)));
            checkOutput($sformatf("rnd%0d ovf sat", i), 32'(oS), 32'(modelOvf(d)));
            prevWrap = modelDout(d, 1'b0);
            prevSat  = modelDout(d, 1'b1);
        end

        // start held high with din=2: done_tick every 4 cycles.
        setInputs(1'b1, 1'b0, 2);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!busWrap.o_done_tick && gap < 20);
        checkOutput("hold first done", 32'(busWrap.o_done_tick), 32'd1);
        for (int k = 0; k < 2; k++) begin
            gap = 0;
            do begin
                tick();
                gap++;
            end while (!busWrap.o_done_tick && gap < 20);
            checkOutput($sformatf("hold gap%0d", k), 32'(gap), 32'd4);
            checkOutput($sformatf("hold dout%0d", k), 32'(busWrap.o_dout), 32'd1);
        end

        // Reset mid-op: outputs clear without any clock edge.
        tick();
        tick();
        checkOutput("hold busy before reset", 32'(busWrap.o_busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset ready", 32'(busWrap.o_ready), 32'd1);
        checkOutput("async reset busy", 32'(busSat.o_busy), 32'd0);
        checkOutput("async reset dout wrap", 32'(busWrap.o_dout), 32'd0);
        checkOutput("async reset dout sat", 32'(busSat.o_dout), 32'd0);
        checkOutput("async reset ovf", 32'(busWrap.o_ovf), 32'd0);
        setInputs(1'b0, 1'b0, 0);
        #3;
        reset = 1'b1;
        tick();
        prevWrap = 0;
        prevSat  = 0;
        applyStimulus("post reset", 12, -1, dW, oW, dS, oS);
        checkOutput("post reset dout wrap", 32'(dW), 32'd16);
        checkOutput("post reset dout sat", 32'(dS), 32'd127);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
